// File: rtl/ucie_ctl_sb_rx_pkg.sv
// ucie_ctl_sb_rx_pkg: sideband packet layout, FSM states and decode codes shared by RX and TX.
package ucie_ctl_sb_rx_pkg;
  localparam int PHASE_W = 32;
  localparam int DP_BIT  = 5;
  localparam int DEC_HI  = 4;
  localparam int DEC_LO  = 0;
  localparam int DEC_W   = DEC_HI - DEC_LO + 1;
  localparam int PAR_BIT = 31;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR1,
    ST_DATA0,
    ST_DATA1,
    ST_DELIVER,
    ST_CREDIT
  } sb_rx_state_t;
  localparam logic [DEC_W-1:0] SB_DEC_NOP     = 5'h00;
  localparam logic [DEC_W-1:0] SB_DEC_ADV_CAP = 5'h01;
  localparam logic [DEC_W-1:0] SB_DEC_LINK_UP = 5'h02;
  localparam logic [DEC_W-1:0] SB_DEC_LINK_DN = 5'h03;
  function automatic logic phase_parity(input logic [PHASE_W-1:0] p);
    return ^p[PAR_BIT-1:0];
  endfunction
endpackage

// File: rtl/ucie_ctl_sb_rx_deser.sv
// ucie_ctl_sb_rx_deser: assembles NC-bit config beats (LSB chunk first) into 32-bit phases.
module ucie_ctl_sb_rx_deser
  import ucie_ctl_sb_rx_pkg::*;
#(
  parameter int NC = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_vld,
  input  logic [NC-1:0]      i_data,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_done
);
  localparam int NB = PHASE_W / NC;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  logic [CW-1:0] r_cnt;
  assign o_done = i_vld && (r_cnt == CW'(NB - 1));
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_cnt <= '0;
    else if (i_vld) r_cnt <= o_done ? '0 : r_cnt + 1'b1;
  end
  generate
    if (NB == 1) begin : g_one
      assign o_phase = i_data;
    end else begin : g_sr
      // earlier beats wait in the low chunks; the live beat completes the top chunk
      logic [PHASE_W-NC-1:0] r_sr;
      assign o_phase = {i_data, r_sr};
      always_ff @(posedge i_clk) begin
        if (!i_rst) r_sr <= '0;
        else if (i_vld) r_sr <= o_phase[PHASE_W-1:NC];
      end
    end
  endgenerate
endmodule

// File: rtl/ucie_ctl_sb_rx.sv
// ucie_ctl_sb_rx: sideband RX packet FSM, message registers and credit return.
// Optional phase1 parity check enabled by macro UCIE_CTL_SB_RX_PARITY_EN.
module ucie_ctl_sb_rx
  import ucie_ctl_sb_rx_pkg::*;
#(
  parameter int NC = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rdi_pl_cfg_vld,
  input  logic [NC-1:0]     i_rdi_pl_cfg,
  output logic              o_rdi_lp_cfg_crd,
  output logic              o_valid_pl_sb,
  input  logic              i_ready_pl_sb,
  output logic [DEC_W-1:0]  o_rdi_pl_sb_decode,
  output logic [31:0]       o_rdi_pl_adv_cap_value,
  output logic              o_sb_rx_err,
  output logic              o_sb_parity_err
);
  sb_rx_state_t r_state, w_next;
  logic [PHASE_W-1:0] w_phase;
  logic [PHASE_W-1:0] r_d0;
  logic [DEC_W-1:0] r_dec;
  logic w_blocked, w_beat, w_done, w_par_bad, w_load;
  logic r_dp, r_seen, r_err;
  assign w_blocked = (r_state == ST_DELIVER) || (r_state == ST_CREDIT);
  assign w_beat = i_rdi_pl_cfg_vld && !w_blocked;
  assign w_load = (w_next == ST_DELIVER) && (r_state != ST_DELIVER);
  assign o_sb_rx_err = r_err;
  ucie_ctl_sb_rx_deser #(.NC(NC)) u_deser (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vld   (w_beat),
    .i_data  (i_rdi_pl_cfg),
    .o_phase (w_phase),
    .o_done  (w_done)
  );
`ifdef UCIE_CTL_SB_RX_PARITY_EN
  logic r_par, r_perr;
  assign w_par_bad = w_phase[PAR_BIT] != r_par;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_par  <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_done) r_par <= phase_parity(w_phase);
      if (r_state == ST_HDR1 && w_done) r_perr <= w_par_bad;
    end
  end
`else
  assign w_par_bad = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = w_done ? ST_HDR1 : ST_IDLE;
      ST_HDR1:    w_next = !w_done ? ST_HDR1 : w_par_bad ? ST_CREDIT : r_dp ? ST_DATA0 : ST_DELIVER;
      ST_DATA0:   w_next = w_done ? ST_DATA1 : ST_DATA0;
      ST_DATA1:   w_next = w_done ? ST_DELIVER : ST_DATA1;
      ST_DELIVER: w_next = i_ready_pl_sb ? ST_CREDIT : ST_DELIVER;
      default:    w_next = ST_IDLE;
    endcase
  end
  // the first cycle out of reset grants the PHY its single outstanding credit
  always_comb begin
    o_valid_pl_sb    = i_rst && (r_state == ST_DELIVER);
    o_rdi_lp_cfg_crd = i_rst && ((r_state == ST_CREDIT) || !r_seen);
`ifdef UCIE_CTL_SB_RX_PARITY_EN
    o_sb_parity_err  = i_rst && (r_state == ST_CREDIT) && r_perr;
`else
    o_sb_parity_err  = 1'b0;
`endif
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_dec                  <= '0;
      r_dp                   <= 1'b0;
      r_d0                   <= '0;
      r_seen                 <= 1'b0;
      r_err                  <= 1'b0;
      o_rdi_pl_sb_decode     <= '0;
      o_rdi_pl_adv_cap_value <= '0;
    end else begin
      r_seen <= 1'b1;
      if (r_state == ST_IDLE && w_done) begin
        r_dec <= w_phase[DEC_HI:DEC_LO];
        r_dp  <= w_phase[DP_BIT];
      end
      if (r_state == ST_DATA0 && w_done) r_d0 <= w_phase;
      if (w_load) begin
        o_rdi_pl_sb_decode <= r_dec;
        if (r_dp) o_rdi_pl_adv_cap_value <= r_d0;
      end
      if (i_rdi_pl_cfg_vld && w_blocked) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ucie_ctl_sb_rx.sv
// tb_ucie_ctl_sb_rx: directed packets with a scoreboard queue checked by a monitor on each accepted message.
module tb_ucie_ctl_sb_rx;
  localparam int NC = 8;
  typedef struct packed {
    logic [4:0]  dec;
    logic [31:0] cap;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, vld = 1'b0, ready = 1'b1;
  logic [NC-1:0] cfg = '0;
  logic crd, valid, rx_err, perr;
  logic [4:0] dec;
  logic [31:0] cap;
  int checks = 0, failures = 0, crd_cnt = 0, perr_cnt = 0, exp_crd = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ucie_ctl_sb_rx #(.NC(NC)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_rdi_pl_cfg_vld       (vld),
    .i_rdi_pl_cfg           (cfg),
    .o_rdi_lp_cfg_crd       (crd),
    .o_valid_pl_sb          (valid),
    .i_ready_pl_sb          (ready),
    .o_rdi_pl_sb_decode     (dec),
    .o_rdi_pl_adv_cap_value (cap),
    .o_sb_rx_err            (rx_err),
    .o_sb_parity_err        (perr)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (crd) crd_cnt++;
    if (perr) perr_cnt++;
  end

  always @(negedge clk) begin
    if (valid && ready) begin
      if (sb.size() == 0) chk("sb_unexpected_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_decode", {27'd0, dec}, {27'd0, e.dec});
        chk("sb_cap", cap, e.cap);
      end
    end
  end

  task automatic send_beat(input logic [NC-1:0] b);
    vld = 1'b1;
    cfg = b;
    @(posedge clk);
    #1;
    vld = 1'b0;
  endtask

  task automatic send_phase(input logic [31:0] p, input bit gaps);
    for (int k = 0; k < 32 / NC; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_beat(p[k*NC +: NC]);
    end
  endtask

  task automatic send_pkt(input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] d0, input logic [31:0] d1, input bit gaps);
    send_phase(p0, gaps);
    send_phase(p1, gaps);
    if (p0[5]) begin
      send_phase(d0, gaps);
      send_phase(d1, gaps);
    end
  endtask

  task automatic wait_crd(input string n);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!crd && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk(n, {31'd0, crd}, 32'd1);
    exp_crd++;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {23'd0, crd, valid, rx_err, perr, dec}, 32'd0);
    chk("rst_cap", cap, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("init_crd", {31'd0, crd}, 32'd1);
    exp_crd++;
    chk("init_others", {24'd0, valid, rx_err, perr, dec}, 32'd0);
    @(negedge clk);
    chk("init_crd_once", {31'd0, crd}, 32'd0);

    sb.push_back({5'h03, 32'h0});
    send_pkt(32'h0000_0003, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("dp0_valid", {31'd0, valid}, 32'd1);
    chk("dp0_crd_early", {31'd0, crd}, 32'd0);
    @(negedge clk);
    chk("dp0_valid_1cyc", {31'd0, valid}, 32'd0);
    chk("dp0_crd_lat2", {31'd0, crd}, 32'd1);
    exp_crd++;
    @(negedge clk);
    chk("dp0_crd_pulse", {31'd0, crd}, 32'd0);

    sb.push_back({5'h01, 32'hA5A5_1234});
    send_pkt(32'h0000_0021, 32'h0, 32'hA5A5_1234, 32'hFFFF_FFFF, 1'b1);
    wait_crd("dp1_crd");
    chk("dp1_cap_hold", cap, 32'hA5A5_1234);

    ready = 1'b0;
    sb.push_back({5'h02, 32'h1234_5678});
    send_pkt(32'h0000_0022, 32'h0, 32'h1234_5678, 32'h0, 1'b0);
    @(negedge clk);
    chk("bp_valid", {31'd0, valid}, 32'd1);
    repeat (9) begin
      @(negedge clk);
      chk("bp_hold", {25'd0, valid, crd, dec}, {25'd0, 1'b1, 1'b0, 5'h02});
      chk("bp_cap", cap, 32'h1234_5678);
    end
    @(posedge clk);
    #1 ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_no_crd", {31'd0, crd}, 32'd0);
    @(negedge clk);
    chk("bp_crd", {31'd0, crd}, 32'd1);
    exp_crd++;
    @(negedge clk);

    ready = 1'b0;
    sb.push_back({5'h04, 32'h1234_5678});
    send_pkt(32'h0000_0004, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    send_beat(8'hFF);
    @(negedge clk);
    chk("err_set", {31'd0, rx_err}, 32'd1);
    chk("err_msg", {26'd0, valid, dec}, {26'd0, 1'b1, 5'h04});
    chk("err_cap", cap, 32'h1234_5678);
    @(posedge clk);
    #1 ready = 1'b1;
    wait_crd("err_crd");
    chk("err_sticky", {31'd0, rx_err}, 32'd1);

    send_phase(32'h0000_0025, 1'b0);
    send_phase(32'h8000_0000, 1'b0);
    send_beat(8'h11);
    send_beat(8'h22);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_zero", {23'd0, crd, valid, rx_err, perr, dec}, 32'd0);
    chk("midrst_cap", cap, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_init_crd", {31'd0, crd}, 32'd1);
    exp_crd++;
    @(negedge clk);
    sb.push_back({5'h07, 32'hCAFE_F00D});
    send_pkt(32'h0000_0027, 32'h0, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b1);
    wait_crd("post_rst_crd");

`ifdef UCIE_CTL_SB_RX_PARITY_EN
    send_pkt(32'h0000_0003, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("par_perr", {31'd0, perr}, 32'd1);
    chk("par_crd", {31'd0, crd}, 32'd1);
    chk("par_no_valid", {31'd0, valid}, 32'd0);
    exp_crd++;
    @(negedge clk);
    chk("par_perr_cnt", perr_cnt, 32'd1);
`else
    chk("perr_tied", perr_cnt, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("crd_total", crd_cnt, exp_crd);
    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
